program_counter: RTL and testbench
==================================

PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 Parameter WIDTH, default 32: bit width of the PC datapath.
REQ-002 Parameter RESET_VALUE, default 32'h0000_0000 (WIDTH bits): value loaded by reset.
REQ-003 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port pc_in  input  WIDTH  next PC value, sampled every rising clk edge.
REQ-006 Port pc_out  output  WIDTH  current PC, registered.
REQ-007 Port pc_prev  output  WIDTH  PC value held before the most recent load, registered.
REQ-008 Port pc_valid  output  1  high once at least one load has completed since reset.
REQ-009 Port declaration order: clk, rst_n, pc_in, pc_out, pc_prev, pc_valid.

Function
REQ-010 On every rising clk edge with rst_n high, pc_out SHALL take the value of pc_in sampled at that edge; no enable, unconditional load.
REQ-011 Latency: pc_in applied before edge N SHALL appear on pc_out after edge N and hold until edge N+1.
REQ-012 pc_out SHALL be driven directly from a register; no combinational path pc_in -> pc_out.
REQ-013 pc_in changes between edges SHALL NOT affect pc_out.
REQ-014 On the same edge as REQ-010, pc_prev SHALL take the old pc_out value.
REQ-015 pc_valid SHALL go high on the first rising edge after rst_n deasserts and stay high until the next reset.
REQ-016 Value is loaded verbatim: no increment, alignment, masking or arithmetic; all WIDTH bits pass through, including 32'hFFFF_FFFF and 32'h0000_0000.
REQ-017 Loading the same value on consecutive edges SHALL leave pc_out unchanged; no side effects.
REQ-018 pc_in containing X/Z SHALL propagate as-is to pc_out (no sanitising).

Reset
REQ-019 rst_n low SHALL immediately, without a clock edge, force pc_out = RESET_VALUE, pc_prev = RESET_VALUE, pc_valid = 0.
REQ-020 While rst_n is low, clock edges SHALL be ignored and outputs held at reset values.
REQ-021 Reset asserted mid-operation SHALL override any pending load; in-flight pc_in is discarded.
REQ-022 Deassertion of rst_n SHALL be clean: the first edge with rst_n high loads pc_in normally (REQ-010).
REQ-023 Before the first reset, output values are undefined; the bench SHALL apply reset before checking.

Verification
REQ-024 rst_n=0 at t=0, no clock -> pc_out=0, pc_prev=0, pc_valid=0 immediately.
REQ-025 Release reset; pc_in=32'h0000_0004, one edge -> pc_out=32'h0000_0004, pc_prev=0, pc_valid=1.
REQ-026 Sequence pc_in=32'h0000_0008, 32'h0000_0100, 32'hFFFF_FFFC on successive edges -> pc_out follows one edge later each; pc_prev lags pc_out by one load.
REQ-027 pc_in toggled 32'hDEAD_BEEF -> 32'h1234_5678 between edges -> pc_out unchanged until next rising edge, then 32'h1234_5678.
REQ-028 pc_in=32'hFFFF_FFFF then 32'h0000_0000 -> pc_out=32'hFFFF_FFFF then 32'h0000_0000; no wrap logic involved.
REQ-029 With pc_out=32'h0000_0100, pulse rst_n low between edges -> pc_out=0, pc_valid=0 immediately; next edge after release loads pc_in.

Source files
------------

// File: rtl/program_counter.sv
// Program counter register: unconditional load of pc_in every rising edge,
// with a one-load history (pc_prev) and a loaded-since-reset flag (pc_valid).
module program_counter #(
    parameter int unsigned          WIDTH       = 32,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pc_in,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_prev,
    output logic             pc_valid
);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_pc_prev;
    logic             r_valid;

    // Verbatim load; the old value shifts into the history register on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= RESET_VALUE;
            r_pc_prev <= RESET_VALUE;
            r_valid   <= 1'b0;
        end else begin
            r_pc      <= pc_in;
            r_pc_prev <= r_pc;
            r_valid   <= 1'b1;
        end
    end

    assign pc_out   = r_pc;
    assign pc_prev  = r_pc_prev;
    assign pc_valid = r_valid;

endmodule

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter.
module tb_program_counter;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] pc_in;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] pc_prev;
    logic             pc_valid;

    int n_tests;
    int n_fail;

    program_counter #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (32'h0000_0000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pc_in    (pc_in),
        .pc_out   (pc_out),
        .pc_prev  (pc_prev),
        .pc_valid (pc_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [WIDTH-1:0] e_out,
                             input logic [WIDTH-1:0] e_prev, input logic e_valid);
        check({tag, ".pc_out"},   pc_out,  e_out);
        check({tag, ".pc_prev"},  pc_prev, e_prev);
        check({tag, ".pc_valid"}, WIDTH'(pc_valid), WIDTH'(e_valid));
    endtask

    // Drive pc_in on the falling edge, then sample just after the rising edge.
    task automatic load(input logic [WIDTH-1:0] v);
        @(negedge clk);
        pc_in = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clk     = 1'b0;
        rst_n   = 1'b0;
        pc_in   = 32'h0000_0000;

        #1;
        check_all("reset_t0", 32'h0, 32'h0, 1'b0);

        // Clock edges during reset must be ignored.
        load(32'h0000_0123);
        check_all("reset_hold", 32'h0, 32'h0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        pc_in = 32'h0000_0004;
        @(posedge clk);
        #1;
        check_all("first_load", 32'h0000_0004, 32'h0, 1'b1);

        load(32'h0000_0008);
        check_all("seq_8", 32'h0000_0008, 32'h0000_0004, 1'b1);
        load(32'h0000_0100);
        check_all("seq_100", 32'h0000_0100, 32'h0000_0008, 1'b1);
        load(32'hFFFF_FFFC);
        check_all("seq_fffc", 32'hFFFF_FFFC, 32'h0000_0100, 1'b1);

        // Mid-cycle pc_in changes must not reach pc_out.
        @(negedge clk);
        pc_in = 32'hDEAD_BEEF;
        #2;
        check("toggle_mid", pc_out, 32'hFFFF_FFFC);
        pc_in = 32'h1234_5678;
        #1;
        check("toggle_mid2", pc_out, 32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        check_all("toggle_edge", 32'h1234_5678, 32'hFFFF_FFFC, 1'b1);

        load(32'hFFFF_FFFF);
        check_all("all_ones", 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        load(32'h0000_0000);
        check_all("all_zeros", 32'h0000_0000, 32'hFFFF_FFFF, 1'b1);

        load(32'hA5A5_5A5A);
        check_all("same_1", 32'hA5A5_5A5A, 32'h0000_0000, 1'b1);
        load(32'hA5A5_5A5A);
        check_all("same_2", 32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b1);

        load(32'h0000_0100);
        check_all("pre_reset", 32'h0000_0100, 32'hA5A5_5A5A, 1'b1);

        // Asynchronous reset pulse between edges discards the pending load.
        @(negedge clk);
        pc_in = 32'h0000_ABCD;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 32'h0, 32'h0, 1'b0);
        #1;
        rst_n = 1'b1;
        #1;
        check_all("after_release", 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        check_all("reload", 32'h0000_ABCD, 32'h0, 1'b1);

        load(32'h8000_0001);
        check_all("post_reload", 32'h8000_0001, 32'h0000_ABCD, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
